// File: rtl/f2sdram_pkg.sv
// Shared types and helpers for the f2sdram burst writer.
package f2sdram_pkg;

    // Write master states: waiting for enough data, or driving a burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Word-address width for a 32-bit byte address space.
    function automatic int addr_width(input int data_width);
        return 32 - $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/f2sdram_wr_fifo.sv
// Show-ahead FIFO: dout always presents the oldest stored word, so the
// burst master can drive it onto writedata without a read latency.
module f2sdram_wr_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64,
    localparam int PTR_WIDTH   = $clog2(DEPTH),
    localparam int COUNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   full,
    output logic                   empty
);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_reg;
    logic [PTR_WIDTH-1:0]   rd_ptr_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count_reg == COUNT_WIDTH'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Head word is read asynchronously from the read pointer (show-ahead).
    assign dout = mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + COUNT_WIDTH'(1);
                2'b01:   count_reg <= count_reg - COUNT_WIDTH'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/f2sdram_burst_writer.sv
// Streaming write master: buffers a valid/ready stream and writes it out as
// fixed-length Avalon-MM bursts into a circular word-addressed region.
module f2sdram_burst_writer
    import f2sdram_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int BURSTCOUNT_WIDTH = 8,
    parameter int BURST_LEN        = 16,
    parameter int FIFO_DEPTH       = 64,
    localparam int ADDRESS_WIDTH   = addr_width(DATA_WIDTH),
    localparam int BE_WIDTH        = DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDRESS_WIDTH-1:0]    base_addr,
    input  logic [ADDRESS_WIDTH-1:0]    buf_words,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        busy,
    input  logic                        waitrequest,
    output logic [BURSTCOUNT_WIDTH-1:0] burstcount,
    output logic [ADDRESS_WIDTH-1:0]    address,
    output logic [DATA_WIDTH-1:0]       writedata,
    output logic [BE_WIDTH-1:0]         byteenable,
    output logic                        write,
    output logic                        read
);

    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDRESS_WIDTH-1:0] BURST_LEN_AW = ADDRESS_WIDTH'(BURST_LEN);

    state_t                        state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0]      base_reg, base_next;
    logic [ADDRESS_WIDTH-1:0]      len_reg, len_next;
    logic [ADDRESS_WIDTH-1:0]      offset_reg, offset_next;
    logic [ADDRESS_WIDTH-1:0]      pbase_reg, pbase_next;
    logic [ADDRESS_WIDTH-1:0]      plen_reg, plen_next;
    logic [BURSTCOUNT_WIDTH-1:0]   beats_left_reg, beats_left_next;
    logic [BURSTCOUNT_WIDTH-1:0]   burstcount_reg, burstcount_next;
    logic [ADDRESS_WIDTH-1:0]      address_reg, address_next;
    logic                          write_reg, write_next;
    logic                          start_pend_reg, start_pend_next;
    logic                          flush_pend_reg, flush_pend_next;

    logic [DATA_WIDTH-1:0]         fifo_dout;
    logic [COUNT_WIDTH-1:0]        fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_push;
    logic                          fifo_pop;

    logic [ADDRESS_WIDTH-1:0]      remain;
    logic [ADDRESS_WIDTH-1:0]      count_aw;
    logic [ADDRESS_WIDTH-1:0]      n_words;
    logic [ADDRESS_WIDTH-1:0]      offset_sum;
    logic [ADDRESS_WIDTH-1:0]      offset_wrapped;
    logic                          burst_go;

    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = write_reg && !waitrequest;

    f2sdram_wr_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Words left before the region end; a burst is never allowed past it.
    assign remain   = len_reg - offset_reg;
    assign count_aw = ADDRESS_WIDTH'(fifo_count);

    // Burst length: smallest of nominal length, buffered words and room left.
    always_comb begin
        n_words = BURST_LEN_AW;
        if (count_aw < n_words) begin
            n_words = count_aw;
        end
        if (remain < n_words) begin
            n_words = remain;
        end
    end

    // Offset after the current burst, wrapping to the region start at the end.
    assign offset_sum     = offset_reg + ADDRESS_WIDTH'(burstcount_reg);
    assign offset_wrapped = (offset_sum == len_reg) ? '0 : offset_sum;

    // A full burst is buffered, or a flush wants whatever is left; an
    // unconfigured (zero-length) region never issues a burst.
    assign burst_go = (remain != '0) &&
                      ((fifo_count >= COUNT_WIDTH'(BURST_LEN)) ||
                       (flush_pend_reg && !fifo_empty));

    // Next-state and next-register logic for the burst master.
    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        len_next        = len_reg;
        offset_next     = offset_reg;
        pbase_next      = pbase_reg;
        plen_next       = plen_reg;
        beats_left_next = beats_left_reg;
        burstcount_next = burstcount_reg;
        address_next    = address_reg;
        write_next      = write_reg;
        start_pend_next = start_pend_reg;
        flush_pend_next = flush_pend_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    // A fresh start overrides any older pending one.
                    base_next       = base_addr;
                    len_next        = buf_words;
                    offset_next     = '0;
                    start_pend_next = 1'b0;
                end else if (start_pend_reg) begin
                    base_next       = pbase_reg;
                    len_next        = plen_reg;
                    offset_next     = '0;
                    start_pend_next = 1'b0;
                end else if (burst_go) begin
                    burstcount_next = BURSTCOUNT_WIDTH'(n_words);
                    beats_left_next = BURSTCOUNT_WIDTH'(n_words);
                    address_next    = base_reg + offset_reg;
                    write_next      = 1'b1;
                    state_next      = BURST;
                end else if (flush_pend_reg && fifo_empty) begin
                    flush_pend_next = 1'b0;
                end
            end
            BURST: begin
                // Region changes wait until the running burst completes.
                if (start) begin
                    start_pend_next = 1'b1;
                    pbase_next      = base_addr;
                    plen_next       = buf_words;
                end
                if (fifo_pop) begin
                    beats_left_next = beats_left_reg - BURSTCOUNT_WIDTH'(1);
                    if (beats_left_reg == BURSTCOUNT_WIDTH'(1)) begin
                        write_next  = 1'b0;
                        offset_next = offset_wrapped;
                        state_next  = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                write_next = 1'b0;
            end
        endcase

        // A flush request is never lost, even while a pending one is cleared.
        if (flush) begin
            flush_pend_next = 1'b1;
        end
    end

    // State and register update; reset aborts any burst immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            len_reg        <= '0;
            offset_reg     <= '0;
            pbase_reg      <= '0;
            plen_reg       <= '0;
            beats_left_reg <= '0;
            burstcount_reg <= '0;
            address_reg    <= '0;
            write_reg      <= 1'b0;
            start_pend_reg <= 1'b0;
            flush_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            len_reg        <= len_next;
            offset_reg     <= offset_next;
            pbase_reg      <= pbase_next;
            plen_reg       <= plen_next;
            beats_left_reg <= beats_left_next;
            burstcount_reg <= burstcount_next;
            address_reg    <= address_next;
            write_reg      <= write_next;
            start_pend_reg <= start_pend_next;
            flush_pend_reg <= flush_pend_next;
        end
    end

    assign in_ready   = !fifo_full;
    assign busy       = (state_reg != IDLE) || !fifo_empty || start_pend_reg || flush_pend_reg;
    assign write      = write_reg;
    assign read       = 1'b0;
    assign burstcount = burstcount_reg;
    assign address    = address_reg;
    assign writedata  = write_reg ? fifo_dout : '0;
    assign byteenable = {BE_WIDTH{write_reg}};

endmodule

// File: tb/tb_f2sdram_burst_writer.sv
// Self-checking bench for f2sdram_burst_writer: directed scenarios plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_f2sdram_burst_writer;

    localparam int AW    = 29;
    localparam int BL    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] buf_words;
    logic          flush;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          busy;
    logic          waitrequest;
    logic [7:0]    burstcount;
    logic [AW-1:0] address;
    logic [63:0]   writedata;
    logic [7:0]    byteenable;
    logic          write;
    logic          read;

    int total = 0;
    int bad   = 0;

    // Model state (what the block's registers must hold this cycle).
    logic [63:0]   q[$];
    bit            in_burst;
    bit            m_spend;
    bit            m_flush;
    logic [AW-1:0] m_base, m_len, m_off, m_pbase, m_plen, exp_addr;
    int            exp_n;
    int            beats_left;
    int            log_addr[$];
    int            log_n[$];

    always #5 clk = ~clk;

    f2sdram_burst_writer #(
        .DATA_WIDTH       (64),
        .BURSTCOUNT_WIDTH (8),
        .BURST_LEN        (BL),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .buf_words   (buf_words),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .busy        (busy),
        .waitrequest (waitrequest),
        .burstcount  (burstcount),
        .address     (address),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .write       (write),
        .read        (read)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: check outputs, then advance the model by one clock.
    always @(negedge clk) begin
        int            cnt;
        bit            push;
        bit            pop;
        logic [AW-1:0] rem;
        int            n;
        if (reset) begin
            chk("rst_write", 64'(write), 64'(0));
            chk("rst_read", 64'(read), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_be", 64'(byteenable), 64'(0));
            chk("rst_wdata", writedata, 64'(0));
            chk("rst_bc", 64'(burstcount), 64'(0));
            chk("rst_addr", 64'(address), 64'(0));
            chk("rst_in_ready", 64'(in_ready), 64'(1));
            q.delete();
            in_burst = 0; m_spend = 0; m_flush = 0;
            m_base = '0; m_len = '0; m_off = '0; m_pbase = '0; m_plen = '0;
            exp_addr = '0; exp_n = 0; beats_left = 0;
        end else begin
            cnt = q.size();
            chk("write", 64'(write), 64'(in_burst));
            chk("read", 64'(read), 64'(0));
            chk("byteenable", 64'(byteenable), in_burst ? 64'hFF : 64'h0);
            chk("busy", 64'(busy), 64'(in_burst || cnt > 0 || m_spend || m_flush));
            chk("in_ready", 64'(in_ready), 64'(cnt < DEPTH));
            if (in_burst) begin
                chk("address", 64'(address), 64'(exp_addr));
                chk("burstcount", 64'(burstcount), 64'(exp_n));
                chk("fifo_has_data", 64'(cnt > 0), 64'(1));
                if (cnt > 0) chk("writedata", writedata, q[0]);
            end else begin
                chk("writedata_idle", writedata, 64'(0));
            end

            push = in_valid && (cnt < DEPTH);
            pop  = in_burst && !waitrequest && (cnt > 0);
            if (in_burst) begin
                if (start) begin
                    m_spend = 1; m_pbase = base_addr; m_plen = buf_words;
                end
                if (pop) begin
                    beats_left--;
                    if (beats_left == 0) begin
                        in_burst = 0;
                        m_off = m_off + AW'(exp_n);
                        if (m_off == m_len) m_off = '0;
                    end
                end
            end else begin
                rem = m_len - m_off;
                if (start) begin
                    m_base = base_addr; m_len = buf_words; m_off = '0; m_spend = 0;
                end else if (m_spend) begin
                    m_base = m_pbase; m_len = m_plen; m_off = '0; m_spend = 0;
                end else if (rem != '0 && (cnt >= BL || (m_flush && cnt > 0))) begin
                    n = BL;
                    if (cnt < n) n = cnt;
                    if (rem < AW'(n)) n = int'(rem);
                    exp_n = n; beats_left = n; exp_addr = m_base + m_off; in_burst = 1;
                    log_addr.push_back(int'(exp_addr));
                    log_n.push_back(n);
                end else if (m_flush && cnt == 0) begin
                    m_flush = 0;
                end
            end
            if (flush) m_flush = 1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        base_addr = b; buf_words = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic issue_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic push_one(input logic [63:0] d);
        bit acc = 0;
        in_valid = 1'b1; in_data = d;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_quiet();
        bit done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (!busy && !in_burst) done = 1;
        end
        if (!done) chk("quiet_timeout", 64'(0), 64'(1));
        tick();
    endtask

    task automatic wait_write();
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (write) done = 1;
        end
        if (!done) chk("write_timeout", 64'(0), 64'(1));
    endtask

    task automatic reset_dut();
        in_valid = 0; start = 0; flush = 0; waitrequest = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_log(input int idx, input int a, input int n);
        chk("log_addr", 64'(log_addr[idx]), 64'(a));
        chk("log_len", 64'(log_n[idx]), 64'(n));
    endtask

    initial begin
        reset = 1'b1; start = 0; flush = 0; in_valid = 0; in_data = '0;
        waitrequest = 0; base_addr = '0; buf_words = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single burst of A0..A3.
        log_addr.delete(); log_n.delete();
        do_start(AW'(32'h100), AW'(8));
        for (int i = 0; i < 4; i++) push_one(64'hA0 + 64'(i));
        wait_quiet();
        chk("s1_count", 64'(log_n.size()), 64'(1));
        expect_log(0, 32'h100, 4);

        // 16 words: bursts wrap around an 8-word region.
        reset_dut();
        log_addr.delete(); log_n.delete();
        do_start(AW'(32'h100), AW'(8));
        for (int i = 0; i < 16; i++) push_one(64'hC0 + 64'(i));
        wait_quiet();
        chk("s2_count", 64'(log_n.size()), 64'(4));
        expect_log(0, 32'h100, 4);
        expect_log(1, 32'h104, 4);
        expect_log(2, 32'h100, 4);
        expect_log(3, 32'h104, 4);

        // waitrequest held for 3 cycles on the second beat.
        reset_dut();
        log_addr.delete(); log_n.delete();
        do_start(AW'(32'h100), AW'(8));
        for (int i = 0; i < 4; i++) push_one(64'hB0 + 64'(i));
        wait_write();
        tick();
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_write", 64'(write), 64'(1));
            chk("hold_data", writedata, 64'hB1);
            chk("hold_addr", 64'(address), 64'h100);
            chk("hold_bc", 64'(burstcount), 64'(4));
            tick();
        end
        waitrequest = 1'b0;
        wait_quiet();
        chk("s3_count", 64'(log_n.size()), 64'(1));

        // 6 words then flush: 4 + short 2.
        reset_dut();
        log_addr.delete(); log_n.delete();
        do_start(AW'(32'h100), AW'(8));
        for (int i = 0; i < 6; i++) push_one(64'hD0 + 64'(i));
        issue_flush();
        wait_quiet();
        chk("s4_busy_fell", 64'(busy), 64'(0));
        chk("s4_count", 64'(log_n.size()), 64'(2));
        expect_log(0, 32'h100, 4);
        expect_log(1, 32'h104, 2);

        // 6-word region, 8 words with flush.
        reset_dut();
        log_addr.delete(); log_n.delete();
        do_start(AW'(32'h100), AW'(6));
        for (int i = 0; i < 8; i++) push_one(64'hE0 + 64'(i));
        issue_flush();
        wait_quiet();
        chk("s5_count", 64'(log_n.size()), 64'(3));
        expect_log(0, 32'h100, 4);
        expect_log(1, 32'h104, 2);
        expect_log(2, 32'h100, 2);

        // Reset during the second beat, then a clean rerun.
        reset_dut();
        do_start(AW'(32'h100), AW'(8));
        for (int i = 0; i < 4; i++) push_one(64'hF0 + 64'(i));
        wait_write();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_write", 64'(write), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        tick();
        reset = 1'b0;
        log_addr.delete(); log_n.delete();
        do_start(AW'(32'h100), AW'(8));
        for (int i = 0; i < 4; i++) push_one(64'hA0 + 64'(i));
        wait_quiet();
        chk("s6_count", 64'(log_n.size()), 64'(1));
        expect_log(0, 32'h100, 4);

        // Randomized traffic, backpressure, flushes and restarts.
        reset_dut();
        do_start(AW'(32'h1FFFFFFC), AW'(10));
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom % 4) != 0;
            in_data     = {$urandom, $urandom};
            waitrequest = ($urandom % 4) == 0;
            flush       = ($urandom % 40) == 0;
            start       = ($urandom % 200) == 0;
            if (start) begin
                base_addr = ($urandom % 2 == 1) ? AW'($urandom) : AW'(32'h1FFFFFF8);
                buf_words = AW'($urandom_range(20, 1));
            end
            tick();
        end
        in_valid = 0; start = 0; flush = 0; waitrequest = 0;
        issue_flush();
        wait_quiet();
        chk("rand_drained", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
